ram_arbiter: RTL and testbench

Shares the single-port synchronous data RAM between the CPU datapath and a host port used for program loading, inspection and debug. The CPU always wins a contended cycle, so it pays no added latency. A starvation counter guarantees host progress by freezing the CPU for one cycle through `cpu_hold`. The block sits between the CPU's RAM control signals (RAM enable, store, X-register address, data bus) and the RAM macro.

---
 rtl/ram_arbiter.sv | 108 ++++++++++
 tb/tb_ram_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares the single-port data RAM between the CPU datapath and the host debug port.
// The CPU wins contended cycles; a starvation counter forces a one-cycle CPU hold so the host always progresses.
module ram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_ram_en,
  input  logic       cpu_ram_we,
  input  logic [7:0] cpu_addr,
  input  logic [7:0] cpu_wdata,
  output logic [7:0] cpu_rdata,
  output logic       cpu_hold,
  input  logic       host_req,
  input  logic       host_we,
  input  logic [7:0] host_addr,
  input  logic [7:0] host_wdata,
  output logic       host_ack,
  output logic [7:0] host_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, WAIT, DATA, ACK} hostState_t;

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  hostState_t state;
  logic [3:0] starveCount;
  logic       hostWeReg;
  logic [7:0] hostAddrReg;
  logic [7:0] hostWdataReg;
  logic       grant;
  logic       cpuActive;

  // Reset suppresses the grant so an aborted request never touches the RAM.
  assign grant     = (state == WAIT) && !reset && (!cpu_ram_en || cpu_hold);
  assign cpuActive = cpu_ram_en && !cpu_hold;
  assign cpu_rdata = mem_rdata;

  always_comb begin
    mem_en    = cpuActive;
    mem_we    = cpuActive && cpu_ram_we;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (grant) begin
      mem_en    = 1'b1;
      mem_we    = hostWeReg;
      mem_addr  = hostAddrReg;
      mem_wdata = hostWdataReg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      starveCount  <= 4'd0;
      cpu_hold     <= 1'b0;
      host_ack     <= 1'b0;
      host_rdata   <= 8'h00;
      hostWeReg    <= 1'b0;
      hostAddrReg  <= 8'h00;
      hostWdataReg <= 8'h00;
    end else begin
      cpu_hold <= 1'b0;
      case (state)
        IDLE: begin
          if (host_req) begin
            hostWeReg    <= host_we;
            hostAddrReg  <= host_addr;
            hostWdataReg <= host_wdata;
            state        <= WAIT;
          end
        end
        WAIT: begin
          if (grant) begin
            starveCount <= 4'd0;
            state       <= DATA;
          end else begin
            starveCount <= starveCount + 4'd1;
            // Reaching the limit freezes the CPU next cycle, which is then a guaranteed grant.
            if (starveCount + 4'd1 == StarveLimit) begin
              cpu_hold <= 1'b1;
            end
          end
        end
        DATA: begin
          if (!hostWeReg) begin
            host_rdata <= mem_rdata;
          end
          host_ack <= 1'b1;
          state    <= ACK;
        end
        ACK: begin
          if (!host_req) begin
            host_ack <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized host/CPU traffic
// checked against a cycle-level reference of the arbitration rules and a shadow memory.
module tb_ram_arbiter;

  localparam int LIMIT = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       cpu_ram_en;
  logic       cpu_ram_we;
  logic [7:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic [7:0] cpu_rdata;
  logic       cpu_hold;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_ack;
  logic [7:0] host_rdata;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  logic [7:0] tbRam  [256];
  logic [7:0] expMem [256];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .cpu_ram_en(cpu_ram_en), .cpu_ram_we(cpu_ram_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_hold(cpu_hold),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM macro: writes on the edge, read data valid the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) tbRam[mem_addr] <= mem_wdata;
      mem_rdata <= tbRam[mem_addr];
    end
  end

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    cpu_ram_en = 1'b0; cpu_ram_we = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [7:0] d);
    nextCycle();
    cpu_ram_en = 1'b1; cpu_ram_we = 1'b1; cpu_addr = a; cpu_wdata = d;
    expMem[a] = d;
  endtask

  task automatic cpuIdleCycle();
    nextCycle();
    cpu_ram_en = 1'b0; cpu_ram_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idleInputs();
    host_req = 1'b1; host_addr = 8'h42;
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      @(negedge clk);
      checks++; if (cpu_hold !== 1'b0) $display("[TB] FAIL reset_hold: got %b expected 0", cpu_hold); else passed++;
      checks++; if (host_ack !== 1'b0) $display("[TB] FAIL reset_ack: got %b expected 0", host_ack); else passed++;
      checks++; if (host_rdata !== 8'h00) $display("[TB] FAIL reset_rdata: got %h expected 00", host_rdata); else passed++;
      checks++; if (mem_en !== 1'b0) $display("[TB] FAIL reset_mem_en: got %b expected 0", mem_en); else passed++;
    end
    nextCycle();
    reset = 1'b0; host_req = 1'b0;
  endtask

  task automatic test_uncontended_read();
    cpuWrite(8'h42, 8'h5A);
    cpuIdleCycle();
    for (int c = 0; c <= 9; c++) begin
      nextCycle();
      host_req = (c < 8); host_we = 1'b0; host_addr = 8'h42;
      @(negedge clk);
      if (c == 0) begin
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL ur_idle_mem_en: got %b expected 0", mem_en); else passed++;
      end
      if (c == 1) begin
        checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h42})
          $display("[TB] FAIL ur_grant: got en=%b we=%b addr=%h expected en=1 we=0 addr=42", mem_en, mem_we, mem_addr); else passed++;
      end
      if (c == 2) begin
        checks++; if (host_ack !== 1'b0) $display("[TB] FAIL ur_data_ack: got %b expected 0", host_ack); else passed++;
      end
      if (c == 3) begin
        checks++; if (host_rdata !== 8'h5A) $display("[TB] FAIL ur_rdata: got %h expected 5a", host_rdata); else passed++;
      end
      if (c >= 3 && c <= 8) begin
        checks++; if (host_ack !== 1'b1) $display("[TB] FAIL hs_ack_high c%0d: got %b expected 1", c, host_ack); else passed++;
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL hs_no_access c%0d: got %b expected 0", c, mem_en); else passed++;
      end
      if (c == 9) begin
        checks++; if (host_ack !== 1'b0) $display("[TB] FAIL hs_ack_drop: got %b expected 0", host_ack); else passed++;
      end
    end
  endtask

  task automatic test_starvation();
    for (int c = 0; c <= 13; c++) begin
      nextCycle();
      host_req = (c < 12); host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hC3;
      cpu_ram_en = (c <= 9); cpu_ram_we = (c == 9);
      cpu_addr = (c == 9) ? 8'h10 : 8'h30; cpu_wdata = 8'hEE;
      @(negedge clk);
      if (c >= 1 && c <= 8) begin
        checks++; if (cpu_hold !== 1'b0) $display("[TB] FAIL st_no_hold c%0d: got %b expected 0", c, cpu_hold); else passed++;
        checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h30})
          $display("[TB] FAIL st_cpu_wins c%0d: got en=%b we=%b addr=%h expected 1/0/30", c, mem_en, mem_we, mem_addr); else passed++;
      end
      if (c == 9) begin
        checks++; if (cpu_hold !== 1'b1) $display("[TB] FAIL st_hold: got %b expected 1", cpu_hold); else passed++;
        checks++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 8'h10, 8'hC3})
          $display("[TB] FAIL st_grant: got en=%b we=%b addr=%h wdata=%h expected 1/1/10/c3", mem_en, mem_we, mem_addr, mem_wdata); else passed++;
      end
      if (c == 10) begin
        checks++; if (cpu_hold !== 1'b0) $display("[TB] FAIL st_hold_width: got %b expected 0", cpu_hold); else passed++;
        checks++; if (host_ack !== 1'b0) $display("[TB] FAIL st_ack_early: got %b expected 0", host_ack); else passed++;
      end
      if (c == 11) begin
        checks++; if (host_ack !== 1'b1) $display("[TB] FAIL st_ack: got %b expected 1", host_ack); else passed++;
        checks++; if (tbRam[8'h10] !== 8'hC3) $display("[TB] FAIL st_ram: got %h expected c3", tbRam[8'h10]); else passed++;
      end
      if (c == 13) begin
        checks++; if (host_ack !== 1'b0) $display("[TB] FAIL st_ack_drop: got %b expected 0", host_ack); else passed++;
      end
    end
    expMem[8'h10] = 8'hC3;
    idleInputs();
  endtask

  task automatic test_back_to_back();
    cpuWrite(8'h20, 8'h11);
    cpuWrite(8'h21, 8'h22);
    cpuIdleCycle();
    for (int c = 0; c <= 5; c++) begin
      nextCycle();
      host_req = (c < 4); host_we = 1'b0; host_addr = 8'h20;
      cpu_ram_en = (c == 2); cpu_ram_we = 1'b0; cpu_addr = 8'h21;
      @(negedge clk);
      if (c == 1) begin
        checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b0, 8'h20})
          $display("[TB] FAIL pm_grant: got en=%b we=%b addr=%h expected 1/0/20", mem_en, mem_we, mem_addr); else passed++;
      end
      if (c == 2) begin
        checks++; if ({mem_en, mem_addr} !== {1'b1, 8'h21})
          $display("[TB] FAIL pm_cpu_in_data: got en=%b addr=%h expected 1/21", mem_en, mem_addr); else passed++;
      end
      if (c == 3) begin
        checks++; if (host_rdata !== 8'h11) $display("[TB] FAIL pm_host_rdata: got %h expected 11", host_rdata); else passed++;
        checks++; if (cpu_rdata !== 8'h22) $display("[TB] FAIL pm_cpu_rdata: got %h expected 22", cpu_rdata); else passed++;
        checks++; if (host_ack !== 1'b1) $display("[TB] FAIL pm_ack: got %b expected 1", host_ack); else passed++;
      end
      if (c == 5) begin
        checks++; if (host_ack !== 1'b0) $display("[TB] FAIL pm_ack_drop: got %b expected 0", host_ack); else passed++;
      end
    end
  endtask

  task automatic test_reset_in_wait();
    for (int c = 0; c <= 5; c++) begin
      nextCycle();
      reset = (c == 4);
      host_req = (c < 4); host_we = 1'b1; host_addr = 8'h55; host_wdata = 8'h99;
      cpu_ram_en = (c < 4); cpu_ram_we = 1'b0; cpu_addr = 8'h31;
      @(negedge clk);
      if (c >= 1 && c <= 3) begin
        checks++; if ({mem_we, mem_addr} !== {1'b0, 8'h31})
          $display("[TB] FAIL rw_denied c%0d: got we=%b addr=%h expected 0/31", c, mem_we, mem_addr); else passed++;
      end
      if (c == 4) begin
        checks++; if (mem_en !== 1'b0) $display("[TB] FAIL rw_reset_no_grant: got %b expected 0", mem_en); else passed++;
      end
      if (c == 5) begin
        checks++; if ({host_ack, mem_en, cpu_hold} !== 3'b000)
          $display("[TB] FAIL rw_after_reset: got ack/en/hold=%b expected 000", {host_ack, mem_en, cpu_hold}); else passed++;
        checks++; if (tbRam[8'h55] === 8'h99) $display("[TB] FAIL rw_ram_untouched: got %h expected not 99", tbRam[8'h55]); else passed++;
      end
    end
    // The starve count must start from zero again, so the hold lands a full LIMIT denials later.
    for (int c = 0; c <= LIMIT + 5; c++) begin
      nextCycle();
      host_req = (c < LIMIT + 4); host_we = 1'b0; host_addr = 8'h20;
      cpu_ram_en = (c <= LIMIT + 1); cpu_addr = 8'h31;
      @(negedge clk);
      if (c >= 1 && c <= LIMIT) begin
        checks++; if (cpu_hold !== 1'b0) $display("[TB] FAIL rw_restart_no_hold c%0d: got %b expected 0", c, cpu_hold); else passed++;
      end
      if (c == LIMIT + 1) begin
        checks++; if ({cpu_hold, mem_en, mem_addr} !== {1'b1, 1'b1, 8'h20})
          $display("[TB] FAIL rw_restart_hold: got hold=%b en=%b addr=%h expected 1/1/20", cpu_hold, mem_en, mem_addr); else passed++;
      end
      if (c == LIMIT + 3) begin
        checks++; if ({host_ack, host_rdata} !== {1'b1, 8'h11})
          $display("[TB] FAIL rw_restart_read: got ack=%b rdata=%h expected 1/11", host_ack, host_rdata); else passed++;
      end
    end
    idleInputs();
  endtask

  task automatic test_random();
    bit         cpuEnPat [LIMIT + 2];
    int         busy, grantCycle, dropCycle;
    bit         holdExp, cpuEn, isGrant;
    logic       hWe, cWe, pendingRead;
    logic [7:0] hAddr, hData, cAddr, cData, expRead, pendingVal, lastRdata;
    pendingRead = 1'b0;
    lastRdata = 8'h11;
    for (int i = 0; i < 16; i++) cpuWrite(8'(8'h80 + i), 8'($urandom));
    cpuIdleCycle();
    for (int t = 0; t < 25; t++) begin
      busy = ($urandom_range(0, 3) == 0) ? 100 : int'($urandom_range(20, 95));
      for (int k = 0; k < LIMIT + 2; k++) cpuEnPat[k] = ($urandom_range(1, 100) <= busy);
      // Grant on the first CPU-idle WAIT cycle, else on the forced hold cycle.
      grantCycle = LIMIT + 1;
      for (int k = LIMIT; k >= 1; k--) if (!cpuEnPat[k]) grantCycle = k;
      holdExp = (grantCycle == LIMIT + 1);
      dropCycle = grantCycle + 3 + int'($urandom_range(0, 2));
      hWe = 1'($urandom); hAddr = 8'(8'h80 + $urandom_range(0, 15)); hData = 8'($urandom);
      expRead = 8'h00;
      for (int c = 0; c <= dropCycle; c++) begin
        nextCycle();
        host_req = (c < dropCycle);
        host_we = (c == 0) ? hWe : 1'($urandom);
        host_addr = (c == 0) ? hAddr : 8'($urandom);
        host_wdata = (c == 0) ? hData : 8'($urandom);
        cpuEn = (c < LIMIT + 2) ? cpuEnPat[c] : ($urandom_range(1, 100) <= busy);
        cWe = 1'($urandom); cAddr = 8'(8'h80 + $urandom_range(0, 15)); cData = 8'($urandom);
        cpu_ram_en = cpuEn; cpu_ram_we = cWe; cpu_addr = cAddr; cpu_wdata = cData;
        isGrant = (c == grantCycle);
        @(negedge clk);
        if (pendingRead) begin
          checks++; if (cpu_rdata !== pendingVal) $display("[TB] FAIL rnd_cpu_rdata t%0d c%0d: got %h expected %h", t, c, cpu_rdata, pendingVal); else passed++;
          pendingRead = 1'b0;
        end
        checks++; if (cpu_hold !== (holdExp && isGrant))
          $display("[TB] FAIL rnd_hold t%0d c%0d: got %b expected %b", t, c, cpu_hold, holdExp && isGrant); else passed++;
        if (isGrant) begin
          checks++; if ({mem_en, mem_we, mem_addr} !== {1'b1, hWe, hAddr})
            $display("[TB] FAIL rnd_grant t%0d: got en=%b we=%b addr=%h expected 1/%b/%h", t, mem_en, mem_we, mem_addr, hWe, hAddr); else passed++;
          if (hWe) begin
            checks++; if (mem_wdata !== hData) $display("[TB] FAIL rnd_grant_wdata t%0d: got %h expected %h", t, mem_wdata, hData); else passed++;
            expMem[hAddr] = hData;
          end else begin
            expRead = expMem[hAddr];
          end
        end else begin
          checks++; if (mem_en !== cpuEn) $display("[TB] FAIL rnd_cpu_en t%0d c%0d: got %b expected %b", t, c, mem_en, cpuEn); else passed++;
          if (cpuEn) begin
            checks++; if ({mem_we, mem_addr} !== {cWe, cAddr})
              $display("[TB] FAIL rnd_cpu_access t%0d c%0d: got we=%b addr=%h expected %b/%h", t, c, mem_we, mem_addr, cWe, cAddr); else passed++;
            if (cWe) expMem[cAddr] = cData;
            else begin pendingRead = 1'b1; pendingVal = expMem[cAddr]; end
          end
        end
        if (c == 0 || c == grantCycle + 1) begin
          checks++; if (host_ack !== 1'b0) $display("[TB] FAIL rnd_ack_low t%0d c%0d: got %b expected 0", t, c, host_ack); else passed++;
        end
        if (c == grantCycle + 2) begin
          if (!hWe) lastRdata = expRead;
          checks++; if ({host_ack, host_rdata} !== {1'b1, lastRdata})
            $display("[TB] FAIL rnd_ack t%0d: got ack=%b rdata=%h expected 1/%h", t, host_ack, host_rdata, lastRdata); else passed++;
        end
      end
    end
    nextCycle();
    idleInputs();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_uncontended_read();
    test_starvation();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
